npc_sequencer: RTL

- Owns the architectural fetch PC and sequences every PC redirect into IF.
- Arbitrates three redirect sources by priority:
  - exception entry (fixed handler address)
  - ERET (return to EPC)
  - taken branch/jump resolved in ID (target from the ID-stage jump-target calculator)
- Enforces the MIPS branch-delay-slot rule: an ID redirect takes effect only after the delay-slot fetch has been accepted.
- Drives the instruction-memory request handshake and tags delay-slot fetches for EPC/BD bookkeeping.

---
 rtl/npc_pkg.sv | 15 +
 rtl/npc_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC sequencer and the CP0/exception logic
// that must agree on the reset and handler addresses.
package npc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } npc_state_e;

    // Word addresses [31:2]: byte 0x0000_3000 and byte 0x0000_1060.
    localparam logic [29:0] RESET_PC_DEFAULT   = 30'h00000C00;
    localparam logic [29:0] HANDLER_PC_DEFAULT = 30'h00000418;

endpackage

// File: rtl/npc_sequencer.sv
// Fetch PC owner: arbitrates exception/ERET/branch redirects and honours the
// MIPS branch delay slot before steering IF to a branch target.
module npc_sequencer
    import npc_pkg::*;
#(
    parameter logic [29:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [29:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        id_redirect,
    input  logic [29:0] id_target,
    input  logic        exc_enter,
    input  logic        eret,
    input  logic [29:0] epc,
    output logic [29:0] pc_if,
    output logic        fetch_req,
    output logic        fetch_is_ds,
    output logic        flush_if
);

    npc_state_e  state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] tgt_q, tgt_d;
    logic        accept;
    logic        trap;

    assign trap   = exc_enter | eret;
    // fetch_req depends only on registered state and stall, never on fetch_ready.
    assign fetch_req   = ~reset & ~stall & (state_q != FLUSH);
    assign accept      = fetch_req & fetch_ready;
    assign flush_if    = ~reset & trap;
    assign fetch_is_ds = ~reset & ((state_q == PEND) |
                         ((state_q == RUN) & id_redirect & ~trap));
    assign pc_if       = pc_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        if (exc_enter) begin
            pc_d    = HANDLER_PC;
            state_d = FLUSH;
            tgt_d   = '0;
        end else if (eret) begin
            pc_d    = epc;
            state_d = FLUSH;
            tgt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (id_redirect) begin
                        if (accept) begin
                            pc_d = id_target;
                        end else begin
                            tgt_d   = id_target;
                            state_d = PEND;
                        end
                    end else if (accept) begin
                        pc_d = pc_q + 30'd1;
                    end
                end
                // ID keeps presenting the same branch here, so id_redirect is ignored.
                PEND: begin
                    if (accept) begin
                        pc_d    = tgt_q;
                        state_d = RUN;
                    end
                end
                FLUSH: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule
